// File: rtl/fifo_memory_core.sv
// fifo_memory_core: single-clock synchronous FIFO with registered read data.
//
// Buffers bursts between a byte producer and a byte consumer in one clock domain.
// Depth is 2**ADDR_WIDTH. Illegal accesses are dropped and never corrupt stored data.
//
// Ports:
//   clk_i            clock; all state changes on the rising edge
//   rst_i            synchronous, active-high reset
//   wr_i             write request; data_in_i stored if the write is accepted
//   rd_i             read request; oldest word popped into data_out_o if not empty
//   data_in_i        write data
//   data_out_o       registered read data; holds between reads
//   fifo_full_o      occupancy == depth
//   fifo_empty_o     occupancy == 0
//   fifo_threshold_o occupancy < THRESHOLD
//   fifo_overflow_o  registered flag: a write was dropped
//   fifo_underflow_o registered flag: a read was refused
//
// Configuration macro:
//   FIFO_STICKY_FLAGS_EN  when defined, overflow/underflow latch until reset.
//                         Undefined (default): each flag lasts one cycle per offending edge.

module fifo_memory_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned THRESHOLD  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_threshold_o,
  output logic                  fifo_overflow_o,
  output logic                  fifo_underflow_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt  = Depth[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ThreshCnt = THRESHOLD[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty;
  logic wr_accept, rd_accept;
  logic wr_illegal, rd_illegal;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // When full, a simultaneous read frees a slot, so the write goes through too.
  assign rd_accept  = rd_i & ~empty;
  assign wr_accept  = wr_i & (~full | rd_i);
  assign wr_illegal = wr_i & full & ~rd_i;
  assign rd_illegal = rd_i & empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

`ifdef FIFO_STICKY_FLAGS_EN
    overflow_d  = overflow_q  | wr_illegal;
    underflow_d = underflow_q | rd_illegal;
`else
    overflow_d  = wr_illegal;
    underflow_d = rd_illegal;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_accept) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  assign data_out_o       = data_out_q;
  assign fifo_full_o      = full;
  assign fifo_empty_o     = empty;
  assign fifo_threshold_o = (count_q < ThreshCnt);
  assign fifo_overflow_o  = overflow_q;
  assign fifo_underflow_o = underflow_q;

endmodule

// File: tb/tb_fifo_memory_core.sv
// Directed testbench for fifo_memory_core (default build, one-cycle error flags).

module tb_fifo_memory_core;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic       fifo_overflow;
  logic       fifo_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_memory_core #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .THRESHOLD (4)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .wr_i            (wr),
    .rd_i            (rd),
    .data_in_i       (data_in),
    .data_out_o      (data_out),
    .fifo_full_o     (fifo_full),
    .fifo_empty_o    (fifo_empty),
    .fifo_threshold_o(fifo_threshold),
    .fifo_overflow_o (fifo_overflow),
    .fifo_underflow_o(fifo_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    wr      = w;
    rd      = r;
    data_in = d;
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'd0;
    do_reset();
    cycle(1'b0, 1'b0, 8'd0);
    check_eq("rst_dout",  {24'd0, data_out}, 0);
    check_eq("rst_empty", {31'd0, fifo_empty}, 1);
    check_eq("rst_full",  {31'd0, fifo_full}, 0);
    check_eq("rst_thr",   {31'd0, fifo_threshold}, 1);
    check_eq("rst_ovf",   {31'd0, fifo_overflow}, 0);
    check_eq("rst_udf",   {31'd0, fifo_underflow}, 0);

    // Single write then read.
    cycle(1'b1, 1'b0, 8'd1);
    check_eq("w1_empty", {31'd0, fifo_empty}, 0);
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("r1_dout",  {24'd0, data_out}, 1);
    check_eq("r1_empty", {31'd0, fifo_empty}, 1);
    check_eq("r1_thr",   {31'd0, fifo_threshold}, 1);

    // Three writes, three reads on consecutive cycles.
    for (int i = 2; i <= 4; i++) cycle(1'b1, 1'b0, 8'(i));
    check_eq("w3_thr", {31'd0, fifo_threshold}, 1);
    for (int i = 2; i <= 4; i++) begin
      cycle(1'b0, 1'b1, 8'd0);
      check_eq("r3_dout", {24'd0, data_out}, 32'(i));
    end
    check_eq("r3_empty", {31'd0, fifo_empty}, 1);
    check_eq("r3_thr",   {31'd0, fifo_threshold}, 1);

    // Fill to 16 and overflow with a 17th write; pointers wrap past 15 here.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
    check_eq("fill_full", {31'd0, fifo_full}, 1);
    check_eq("fill_ovf",  {31'd0, fifo_overflow}, 0);
    check_eq("fill_thr",  {31'd0, fifo_threshold}, 0);
    cycle(1'b1, 1'b0, 8'd17);
    check_eq("ovf_set",  {31'd0, fifo_overflow}, 1);
    check_eq("ovf_full", {31'd0, fifo_full}, 1);
    cycle(1'b0, 1'b0, 8'd0);
    check_eq("ovf_clr",  {31'd0, fifo_overflow}, 0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'd0);
      check_eq("drain16_dout", {24'd0, data_out}, 32'(i));
    end
    check_eq("drain16_empty", {31'd0, fifo_empty}, 1);
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("udf_set",  {31'd0, fifo_underflow}, 1);
    check_eq("udf_hold", {24'd0, data_out}, 16);
    // Back-to-back illegal reads keep the flag high.
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("udf_b2b", {31'd0, fifo_underflow}, 1);
    cycle(1'b0, 1'b0, 8'd0);
    check_eq("udf_clr", {31'd0, fifo_underflow}, 0);

    // Half-fill after reset.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b0, 1'b0, 8'd0);
    check_eq("half_full",  {31'd0, fifo_full}, 0);
    check_eq("half_empty", {31'd0, fifo_empty}, 0);
    check_eq("half_thr",   {31'd0, fifo_threshold}, 0);
    check_eq("half_ovf",   {31'd0, fifo_overflow}, 0);
    check_eq("half_udf",   {31'd0, fifo_underflow}, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 8'd0);
      check_eq("half_dout", {24'd0, data_out}, 32'(i));
    end
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("half_udf_end", {31'd0, fifo_underflow}, 1);

    // Simultaneous rd & wr while full.
    do_reset();
    for (int i = 10; i <= 25; i++) cycle(1'b1, 1'b0, 8'(i));
    check_eq("rw_full_pre", {31'd0, fifo_full}, 1);
    cycle(1'b1, 1'b1, 8'd99);
    check_eq("rw_full_ovf",  {31'd0, fifo_overflow}, 0);
    check_eq("rw_full_dout", {24'd0, data_out}, 10);
    check_eq("rw_full_full", {31'd0, fifo_full}, 1);
    for (int i = 11; i <= 25; i++) begin
      cycle(1'b0, 1'b1, 8'd0);
      check_eq("rw_full_drain", {24'd0, data_out}, 32'(i));
    end
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("rw_full_last", {24'd0, data_out}, 99);
    check_eq("rw_full_empty", {31'd0, fifo_empty}, 1);

    // Simultaneous rd & wr while empty: write only, underflow flagged.
    cycle(1'b1, 1'b1, 8'd55);
    check_eq("rw_empty_udf",   {31'd0, fifo_underflow}, 1);
    check_eq("rw_empty_dout",  {24'd0, data_out}, 99);
    check_eq("rw_empty_empty", {31'd0, fifo_empty}, 0);
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("rw_empty_read",  {24'd0, data_out}, 55);
    check_eq("rw_empty_udf2",  {31'd0, fifo_underflow}, 0);

    // Reset has priority over a concurrent write.
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'd77);
    rst = 1'b0;
    check_eq("rstpri_empty", {31'd0, fifo_empty}, 1);
    check_eq("rstpri_dout",  {24'd0, data_out}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
